// File: rtl/disp_pixbuf_pkg.sv
// ---------------------------------------------------------------------------
// disp_pixbuf_pkg
// Shared constants for the display pixel buffer.
//   - Default FIFO geometry and the controller's burst/outstanding figures.
//   - Byte lanes of a 32-bit XRGB pixel.
//   - Helper that strips the X byte from an XRGB pixel.
// ---------------------------------------------------------------------------
package disp_pixbuf_pkg;

  localparam int DEF_DEPTH_LOG2  = 9;   // 512 x 64-bit words
  localparam int DEF_BURST_WORDS = 32;  // beats per AXI burst
  localparam int DEF_OUTSTANDING = 2;   // bursts in flight after BUF_WREADY

  localparam int R_MSB = 23;
  localparam int R_LSB = 16;
  localparam int G_MSB = 15;
  localparam int G_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  // XRGB (X in [31:24]) -> {R,G,B}
  function automatic logic [23:0] xrgb_to_rgb(input logic [31:0] px);
    return {px[R_MSB:R_LSB], px[G_MSB:G_LSB], px[B_MSB:B_LSB]};
  endfunction

endpackage

// File: rtl/disp_pixbuf_ram.sv
// ---------------------------------------------------------------------------
// disp_pixbuf_ram
// Simple dual-port RAM, one write port and one registered read port on ACLK.
// The array has no reset so it maps onto block RAM. The read register only
// updates when re_i is high, so it doubles as the FIFO's prefetched head word.
// Ports:
//   ACLK     clock
//   we_i     write enable, waddr_i / wdata_i write address / data
//   re_i     read enable,  raddr_i read address
//   rdata_o  registered read data (holds when re_i is low)
// ---------------------------------------------------------------------------
module disp_pixbuf_ram #(
  parameter int AW = 9,
  parameter int DW = 64
) (
  input  logic          ACLK,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge ACLK) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/disp_pixbuf.sv
// ---------------------------------------------------------------------------
// disp_pixbuf
// Pixel FIFO behind the VRAM read controller. Stores the 64-bit AXI read
// beats the controller accepts and hands them to the display timing stage as
// two 24-bit pixels per word (low half first, X byte dropped).
// Ports:
//   ACLK, ARESETN   clock, asynchronous active-low reset
//   CLR             synchronous flush at frame start
//   RDATA, RVALID   AXI read data / valid
//   RREADY          controller's RREADY (monitored only)
//   BUF_WREADY      room for OUTSTANDING full bursts (registered)
//   PIX_REQ         display stage takes one pixel this cycle
//   PIX_VALID       PIX_DATA holds a fresh pixel (registered)
//   PIX_DATA        {R,G,B}
//   OVERFLOW        sticky: beat arrived while full
//   UNDERFLOW       sticky: PIX_REQ with no pixel available
// count includes the word sitting in the prefetch (RAM read) register, so a
// word is only released once both of its pixels have been consumed.
// ---------------------------------------------------------------------------
module disp_pixbuf
  import disp_pixbuf_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int BURST_WORDS = DEF_BURST_WORDS,
  parameter int OUTSTANDING = DEF_OUTSTANDING
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        CLR,
  input  logic [63:0] RDATA,
  input  logic        RVALID,
  input  logic        RREADY,
  output logic        BUF_WREADY,
  input  logic        PIX_REQ,
  output logic        PIX_VALID,
  output logic [23:0] PIX_DATA,
  output logic        OVERFLOW,
  output logic        UNDERFLOW
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] CNT_FULL  = CW'(1 << DEPTH_LOG2);
  localparam logic [CW-1:0] RESERVE_C = CW'(OUTSTANDING * BURST_WORDS);

  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  half_q, half_d;
  logic                  head_valid_q, head_valid_d;
  logic                  pix_valid_q, pix_valid_d;
  logic [23:0]           pix_data_q, pix_data_d;
  logic                  wready_q, wready_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  wr, full, wr_en, pix_take, pop, rd_en, ram_has_word;
  logic [CW-1:0]         free_next;
  logic [63:0]           head_word;

  assign wr       = RVALID && RREADY;
  assign full     = (count_q == CNT_FULL);
  assign wr_en    = wr && !full && !CLR;
  assign pix_take = PIX_REQ && head_valid_q && !CLR;
  assign pop      = pix_take && half_q;
  // Words still waiting in the array (count minus the one already prefetched).
  assign ram_has_word = (count_q != {{DEPTH_LOG2{1'b0}}, head_valid_q});
  // Refill the head register in the same cycle it is vacated so back-to-back
  // requests keep one pixel per clock across word boundaries.
  assign rd_en    = !CLR && ram_has_word && (!head_valid_q || pop);

  disp_pixbuf_ram #(
    .AW (DEPTH_LOG2),
    .DW (64)
  ) u_ram (
    .ACLK    (ACLK),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (RDATA),
    .re_i    (rd_en),
    .raddr_i (rptr_q),
    .rdata_o (head_word)
  );

  always_comb begin
    wptr_d       = wptr_q + {{(DEPTH_LOG2-1){1'b0}}, wr_en};
    rptr_d       = rptr_q + {{(DEPTH_LOG2-1){1'b0}}, rd_en};
    count_d      = count_q + {{DEPTH_LOG2{1'b0}}, wr_en} - {{DEPTH_LOG2{1'b0}}, pop};
    half_d       = half_q;
    head_valid_d = head_valid_q;
    pix_valid_d  = pix_take;
    pix_data_d   = pix_data_q;
    ovf_d        = ovf_q | (wr && full);
    unf_d        = unf_q | (PIX_REQ && !head_valid_q);

    if (pix_take) begin
      half_d     = ~half_q;
      pix_data_d = half_q ? xrgb_to_rgb(head_word[63:32]) : xrgb_to_rgb(head_word[31:0]);
    end

    if (rd_en) begin
      head_valid_d = 1'b1;
    end else if (pop) begin
      head_valid_d = 1'b0;
    end

    // Space left after this cycle's write/pop settle.
    free_next = CNT_FULL - count_d;
    wready_d  = (free_next >= RESERVE_C);

    if (CLR) begin
      wptr_d       = '0;
      rptr_d       = '0;
      count_d      = '0;
      half_d       = 1'b0;
      head_valid_d = 1'b0;
      pix_valid_d  = 1'b0;
      ovf_d        = 1'b0;
      unf_d        = 1'b0;
      wready_d     = 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      half_q       <= 1'b0;
      head_valid_q <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      wready_q     <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      half_q       <= half_d;
      head_valid_q <= head_valid_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      wready_q     <= wready_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  assign BUF_WREADY = wready_q;
  assign PIX_VALID  = pix_valid_q;
  assign PIX_DATA   = pix_data_q;
  assign OVERFLOW   = ovf_q;
  assign UNDERFLOW  = unf_q;

endmodule

// File: tb/tb_disp_pixbuf.sv
// ---------------------------------------------------------------------------
// tb_disp_pixbuf
// Directed bench for disp_pixbuf: a short table of single-cycle vectors
// followed by hand-written sequences for bursts, fill levels, overflow,
// sustained streaming, flush and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_disp_pixbuf;

  logic        ACLK;
  logic        ARESETN;
  logic        CLR;
  logic [63:0] RDATA;
  logic        RVALID;
  logic        RREADY;
  logic        BUF_WREADY;
  logic        PIX_REQ;
  logic        PIX_VALID;
  logic [23:0] PIX_DATA;
  logic        OVERFLOW;
  logic        UNDERFLOW;

  int n_vec = 0;
  int n_err = 0;

  disp_pixbuf dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .CLR        (CLR),
    .RDATA      (RDATA),
    .RVALID     (RVALID),
    .RREADY     (RREADY),
    .BUF_WREADY (BUF_WREADY),
    .PIX_REQ    (PIX_REQ),
    .PIX_VALID  (PIX_VALID),
    .PIX_DATA   (PIX_DATA),
    .OVERFLOW   (OVERFLOW),
    .UNDERFLOW  (UNDERFLOW)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        clr;
    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic        req;
    logic        e_valid;
    logic        chk_data;
    logic [23:0] e_data;
    logic        e_wready;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t tbl [17];

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    CLR = 1'b0; RVALID = 1'b0; RREADY = 1'b0; RDATA = '0; PIX_REQ = 1'b0;
  endtask

  task automatic do_clr();
    idle_in();
    CLR = 1'b1;
    step();
    CLR = 1'b0;
  endtask

  function automatic logic [63:0] seq_word(input int k);
    logic [31:0] lo, hi;
    lo = 32'(2 * k);
    hi = 32'(2 * k + 1);
    return {hi, lo};
  endfunction

  task automatic put(input logic [63:0] d);
    RVALID = 1'b1; RREADY = 1'b1; RDATA = d;
    step();
    RVALID = 1'b0; RREADY = 1'b0;
  endtask

  int p;

  initial begin
    idle_in();
    ARESETN = 1'b1;
    #1 ARESETN = 1'b0;
    #2;
    chk("rst_wready", BUF_WREADY, 0);
    chk("rst_valid", PIX_VALID, 0);
    chk("rst_data", PIX_DATA, 0);
    chk("rst_flags", {OVERFLOW, UNDERFLOW}, 0);
    step();
    step();
    ARESETN = 1'b1;

    //            clr rv rr rdata                  req ev cd e_data     wr ov un
    tbl[0]  = '{1'b0,1'b0,1'b0,64'h0,                  1'b0,1'b0,1'b0,24'h0,     1'b1,1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b1,64'hFF11_2233_EE44_5566,1'b0,1'b0,1'b0,24'h0,     1'b1,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b1,64'h0077_8899_00AA_BBCC,1'b0,1'b0,1'b0,24'h0,     1'b1,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b0,64'h0,                  1'b1,1'b1,1'b1,24'h445566,1'b1,1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b0,64'h0,                  1'b1,1'b1,1'b1,24'h112233,1'b1,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b0,64'h0,                  1'b0,1'b0,1'b0,24'h0,     1'b1,1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b0,64'h0,                  1'b1,1'b1,1'b1,24'hAABBCC,1'b1,1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b0,1'b0,64'h0,                  1'b1,1'b1,1'b1,24'h778899,1'b1,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b0,64'h0,                  1'b1,1'b0,1'b1,24'h778899,1'b1,1'b0,1'b1};
    tbl[9]  = '{1'b0,1'b0,1'b0,64'h0,                  1'b0,1'b0,1'b0,24'h0,     1'b1,1'b0,1'b1};
    tbl[10] = '{1'b1,1'b1,1'b1,64'h1234_5678_9ABC_DEF0,1'b0,1'b0,1'b0,24'h0,     1'b1,1'b0,1'b0};
    tbl[11] = '{1'b0,1'b0,1'b0,64'h0,                  1'b1,1'b0,1'b0,24'h0,     1'b1,1'b0,1'b1};
    tbl[12] = '{1'b1,1'b0,1'b0,64'h0,                  1'b0,1'b0,1'b0,24'h0,     1'b1,1'b0,1'b0};
    tbl[13] = '{1'b0,1'b1,1'b0,64'h5555_5555_5555_5555,1'b0,1'b0,1'b0,24'h0,     1'b1,1'b0,1'b0};
    tbl[14] = '{1'b0,1'b0,1'b0,64'h0,                  1'b0,1'b0,1'b0,24'h0,     1'b1,1'b0,1'b0};
    tbl[15] = '{1'b0,1'b0,1'b0,64'h0,                  1'b0,1'b0,1'b0,24'h0,     1'b1,1'b0,1'b0};
    tbl[16] = '{1'b0,1'b0,1'b0,64'h0,                  1'b1,1'b0,1'b0,24'h0,     1'b1,1'b0,1'b1};

    for (int i = 0; i < 17; i++) begin
      CLR = tbl[i].clr; RVALID = tbl[i].rvalid; RREADY = tbl[i].rready;
      RDATA = tbl[i].rdata; PIX_REQ = tbl[i].req;
      step();
      $display("vec %0d: valid=%0b data=%06h wready=%0b ovf=%0b unf=%0b",
               i, PIX_VALID, PIX_DATA, BUF_WREADY, OVERFLOW, UNDERFLOW);
      chk($sformatf("tbl%0d_valid", i), PIX_VALID, tbl[i].e_valid);
      if (tbl[i].chk_data) chk($sformatf("tbl%0d_data", i), PIX_DATA, tbl[i].e_data);
      chk($sformatf("tbl%0d_wready", i), BUF_WREADY, tbl[i].e_wready);
      chk($sformatf("tbl%0d_ovf", i), OVERFLOW, tbl[i].e_ovf);
      chk($sformatf("tbl%0d_unf", i), UNDERFLOW, tbl[i].e_unf);
    end
    idle_in();

    // One burst, then 64 back-to-back pixel requests, then one too many.
    do_clr();
    for (int k = 0; k < 32; k++) put(seq_word(k));
    step(); step();
    PIX_REQ = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      chk($sformatf("burst_valid%0d", i), PIX_VALID, 1);
      chk($sformatf("burst_data%0d", i), PIX_DATA, 24'(i));
    end
    step();
    PIX_REQ = 1'b0;
    chk("burst_after_valid", PIX_VALID, 0);
    chk("burst_after_unf", UNDERFLOW, 1);
    $display("burst sequence done");

    // Fill threshold for BUF_WREADY.
    do_clr();
    for (int k = 0; k < 448; k++) begin
      put(seq_word(k));
      chk($sformatf("fill_wready%0d", k), BUF_WREADY, 1);
    end
    put(seq_word(448));
    chk("fill449_wready", BUF_WREADY, 0);
    PIX_REQ = 1'b1;
    step();
    chk("pop_half_wready", BUF_WREADY, 0);
    step();
    PIX_REQ = 1'b0;
    chk("pop_word_wready", BUF_WREADY, 1);
    $display("threshold sequence done");

    // Fill to full, overflow beat, then drain.
    do_clr();
    for (int k = 0; k < 512; k++) put(seq_word(k));
    chk("full_no_ovf", OVERFLOW, 0);
    put(64'h0000_DEAD_0000_DEAD);
    chk("full_ovf", OVERFLOW, 1);
    PIX_REQ = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      step();
      chk($sformatf("drain_valid%0d", i), PIX_VALID, 1);
      chk($sformatf("drain_data%0d", i), PIX_DATA, 24'(i));
    end
    step();
    PIX_REQ = 1'b0;
    chk("drain_empty_valid", PIX_VALID, 0);
    chk("drain_ovf_sticky", OVERFLOW, 1);
    $display("overflow sequence done");

    // Sustained streaming: one beat per two cycles, one pixel per cycle.
    do_clr();
    for (int k = 0; k < 8; k++) put(seq_word(k));
    step(); step();
    p = 0;
    for (int i = 0; i < 10000; i++) begin
      RVALID = (i % 2 == 0); RREADY = (i % 2 == 0);
      RDATA = seq_word(8 + i / 2);
      PIX_REQ = 1'b1;
      step();
      chk($sformatf("stream_valid%0d", i), PIX_VALID, 1);
      chk($sformatf("stream_data%0d", i), PIX_DATA, 24'(p));
      p++;
    end
    idle_in();
    step();
    chk("stream_flags", {OVERFLOW, UNDERFLOW}, 0);
    chk("stream_wready", BUF_WREADY, 1);
    $display("stream sequence done");

    // Flush mid-burst with a beat present.
    do_clr();
    PIX_REQ = 1'b1;
    step();
    PIX_REQ = 1'b0;
    chk("pre_clr_unf", UNDERFLOW, 1);
    for (int k = 0; k < 100; k++) put(seq_word(k));
    CLR = 1'b1; RVALID = 1'b1; RREADY = 1'b1; RDATA = 64'h0000_BEEF_0000_BEEF;
    step();
    idle_in();
    chk("clr_valid", PIX_VALID, 0);
    chk("clr_flags", {OVERFLOW, UNDERFLOW}, 0);
    chk("clr_wready", BUF_WREADY, 1);
    step(); step();
    PIX_REQ = 1'b1;
    step();
    PIX_REQ = 1'b0;
    chk("post_clr_valid", PIX_VALID, 0);
    chk("post_clr_unf", UNDERFLOW, 1);

    // Asynchronous reset while pixels are streaming.
    do_clr();
    for (int k = 0; k < 4; k++) put(seq_word(k));
    step(); step();
    PIX_REQ = 1'b1;
    step();
    chk("pre_rst_valid", PIX_VALID, 1);
    #2 ARESETN = 1'b0;
    #1;
    chk("arst_valid", PIX_VALID, 0);
    chk("arst_data", PIX_DATA, 0);
    chk("arst_wready", BUF_WREADY, 0);
    chk("arst_flags", {OVERFLOW, UNDERFLOW}, 0);
    PIX_REQ = 1'b0;
    step();
    ARESETN = 1'b1;
    step();
    chk("post_rst_wready", BUF_WREADY, 1);
    $display("flush/reset sequence done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
